// File: rtl/spdif_pkg.sv
// ---------------------------------------------------------------------------
// spdif_pkg
// Shared constants and types for the S/PDIF subframe decoder: interval
// codes, preamble codes, decoder state encoding and the decoded subframe
// payload.
// ---------------------------------------------------------------------------
package spdif_pkg;

    // Subframe geometry: data slots 4..31 and the audio part (slots 4..27)
    localparam int unsigned SLOT_BITS  = 28;
    localparam int unsigned AUDIO_BITS = 24;
    localparam int unsigned PRE_LEN    = 4;
    localparam int unsigned BIT_CNT_W  = 5;
    localparam int unsigned LOCK_CNT_W = 4;
    localparam int unsigned IV_W       = 2;
    localparam int unsigned PRE_CNT_W  = 2;

    // Bit positions of V/U/C/P inside the assembled 28-bit slot word
    localparam int unsigned V_IDX = 24;
    localparam int unsigned U_IDX = 25;
    localparam int unsigned C_IDX = 26;

    // Interval codes as produced from the edge-detector flags
    typedef enum logic [IV_W-1:0] {
        IV_NONE = 2'd0,
        IV_S    = 2'd1,
        IV_M    = 2'd2,
        IV_L    = 2'd3
    } iv_e;

    // Preamble codes; PRE_NONE doubles as "no sequence history"
    typedef enum logic [1:0] {
        PRE_NONE = 2'd0,
        PRE_B    = 2'd1,
        PRE_M    = 2'd2,
        PRE_W    = 2'd3
    } pre_e;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Decoded subframe as held on the outputs between strobes
    typedef struct packed {
        logic [AUDIO_BITS-1:0] sample;
        logic                  valid;
        logic                  user;
        logic                  cstat;
        logic                  parity_err;
        logic                  channel;
        logic                  block_start;
    } subframe_t;

endpackage

// File: rtl/spdif_preamble_matcher.sv
// ---------------------------------------------------------------------------
// spdif_preamble_matcher
// Classifies a 4-interval history as one of the B/M/W preambles.
// Purely combinational.
//   i_hist  : interval history, index 0 = first (oldest) interval
//   o_match : history is a valid preamble
//   o_code  : which preamble (PRE_NONE when no match)
// ---------------------------------------------------------------------------
module spdif_preamble_matcher
    import spdif_pkg::*;
(
    input  logic [PRE_LEN-1:0][IV_W-1:0] i_hist,
    output logic                         o_match,
    output pre_e                         o_code
);

    logic is_b;
    logic is_m;
    logic is_w;

    // B = L,S,S,L   M = L,L,S,S   W = L,M,S,M
    always_comb begin
        is_b = (i_hist[0] == IV_L) && (i_hist[1] == IV_S) &&
               (i_hist[2] == IV_S) && (i_hist[3] == IV_L);
        is_m = (i_hist[0] == IV_L) && (i_hist[1] == IV_L) &&
               (i_hist[2] == IV_S) && (i_hist[3] == IV_S);
        is_w = (i_hist[0] == IV_L) && (i_hist[1] == IV_M) &&
               (i_hist[2] == IV_S) && (i_hist[3] == IV_M);

        o_match = is_b | is_m | is_w;
        o_code  = PRE_NONE;
        if (is_b) begin
            o_code = PRE_B;
        end else if (is_m) begin
            o_code = PRE_M;
        end else if (is_w) begin
            o_code = PRE_W;
        end
    end

endmodule

// File: rtl/spdif_subframe_decoder.sv
// ---------------------------------------------------------------------------
// spdif_subframe_decoder
// Turns S/M/L interval strobes from the S/PDIF edge detector into decoded
// subframes: preamble recognition, biphase-mark slot decoding, parity and
// B/M/W sequencing checks, and a lock indicator.
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_zero/i_one/i_head : 1 UI / 2 UI / 3 UI interval ended this cycle
//   i_shift_ena         : qualifies the interval flags
//   o_sample            : audio sample (slots 4..27), LSB received first
//   o_valid/o_user/o_cstat : V/U/C bits
//   o_parity_err        : slots 4..31 have odd parity
//   o_channel           : 0 = B/M subframe, 1 = W subframe
//   o_block_start       : subframe carried a B preamble
//   o_stb               : one-cycle strobe, data outputs held until next one
//   o_lock              : LOCK_FRAMES consecutive good subframes seen
// ---------------------------------------------------------------------------
module spdif_subframe_decoder
    import spdif_pkg::*;
#(
    parameter int unsigned OUT_W       = 24,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_zero,
    input  logic             i_one,
    input  logic             i_head,
    input  logic             i_shift_ena,
    output logic [OUT_W-1:0] o_sample,
    output logic             o_valid,
    output logic             o_user,
    output logic             o_cstat,
    output logic             o_parity_err,
    output logic             o_channel,
    output logic             o_block_start,
    output logic             o_stb,
    output logic             o_lock
);

    state_e                          state_q,    state_d;
    logic [PRE_CNT_W-1:0]            pre_cnt_q,  pre_cnt_d;
    logic [PRE_LEN-2:0][IV_W-1:0]    hist_q,     hist_d;
    pre_e                            code_q,     code_d;
    pre_e                            seq_q,      seq_d;
    logic [BIT_CNT_W-1:0]            bit_cnt_q,  bit_cnt_d;
    logic                            half_q,     half_d;
    logic [SLOT_BITS-2:0]            sh_q,       sh_d;
    logic [LOCK_CNT_W-1:0]           lock_cnt_q, lock_cnt_d;
    subframe_t                       pay_q,      pay_d;
    logic                            stb_q,      stb_d;
    logic                            lock_q,     lock_d;

    logic                            ev_s;
    logic                            ev_m;
    logic                            ev_l;
    logic                            ev_any;
    logic                            ev_bad;
    logic [IV_W-1:0]                 ev_iv;
    logic [PRE_LEN-1:0][IV_W-1:0]    match_hist;
    logic                            pre_match;
    pre_e                            pre_code;

    logic                            err;
    logic                            restart;
    logic                            bit_done;
    logic                            bit_val;
    logic [SLOT_BITS-1:0]            word;
    logic                            seq_err;

    // Event classification: exactly one flag qualified by shift enable
    always_comb begin
        ev_s   = i_shift_ena &  i_zero & ~i_one & ~i_head;
        ev_m   = i_shift_ena & ~i_zero &  i_one & ~i_head;
        ev_l   = i_shift_ena & ~i_zero & ~i_one &  i_head;
        ev_any = ev_s | ev_m | ev_l;
        ev_bad = i_shift_ena & ~ev_any;
        ev_iv  = ev_l ? IV_L : (ev_m ? IV_M : IV_S);
        // The current event completes the history as its 4th interval
        match_hist = {ev_iv, hist_q};
    end

    spdif_preamble_matcher u_matcher (
        .i_hist  (match_hist),
        .o_match (pre_match),
        .o_code  (pre_code)
    );

    // Next-state, datapath and output computation
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        hist_d     = hist_q;
        code_d     = code_q;
        seq_d      = seq_q;
        bit_cnt_d  = bit_cnt_q;
        half_d     = half_q;
        sh_d       = sh_q;
        lock_cnt_d = lock_cnt_q;
        pay_d      = pay_q;
        stb_d      = 1'b0;
        err        = 1'b0;
        restart    = 1'b0;
        bit_done   = 1'b0;
        bit_val    = 1'b0;
        word       = {1'b0, sh_q};
        seq_err    = 1'b0;

        if (ev_bad) begin
            err = 1'b1;
        end else if (ev_any) begin
            unique case (state_q)
                HUNT: begin
                    if (ev_l) begin
                        state_d   = PRE;
                        hist_d[0] = IV_L;
                        pre_cnt_d = PRE_CNT_W'(1);
                    end
                end

                PRE: begin
                    if (pre_cnt_q == PRE_CNT_W'(0)) begin
                        // Waiting for the first interval after a subframe
                        if (ev_l) begin
                            hist_d[0] = IV_L;
                            pre_cnt_d = PRE_CNT_W'(1);
                        end else begin
                            err = 1'b1;
                        end
                    end else if (pre_cnt_q != PRE_CNT_W'(3)) begin
                        if (pre_cnt_q == PRE_CNT_W'(1)) begin
                            hist_d[1] = ev_iv;
                        end else begin
                            hist_d[2] = ev_iv;
                        end
                        pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
                    end else if (pre_match) begin
                        state_d   = DATA;
                        code_d    = pre_code;
                        pre_cnt_d = PRE_CNT_W'(0);
                        bit_cnt_d = BIT_CNT_W'(0);
                        half_d    = 1'b0;
                    end else begin
                        err = 1'b1;
                    end
                end

                DATA: begin
                    // Biphase mark: M = 0, S+S = 1; anything else breaks the slot
                    if (ev_l) begin
                        err     = 1'b1;
                        restart = 1'b1;
                    end else if (ev_m) begin
                        if (half_q) begin
                            err = 1'b1;
                        end else begin
                            bit_done = 1'b1;
                        end
                    end else if (half_q) begin
                        half_d   = 1'b0;
                        bit_done = 1'b1;
                        bit_val  = 1'b1;
                    end else begin
                        half_d = 1'b1;
                    end

                    if (bit_done) begin
                        // Shift in from the MSB so slot 4 ends up in bit 0
                        word = {bit_val, sh_q};
                        sh_d = word[SLOT_BITS-1:1];
                        if (bit_cnt_q == BIT_CNT_W'(SLOT_BITS - 1)) begin
                            seq_err = ((seq_q == PRE_W) && (code_q == PRE_W)) ||
                                      (((seq_q == PRE_B) || (seq_q == PRE_M)) &&
                                       (code_q != PRE_W));

                            pay_d.sample      = word[AUDIO_BITS-1:0];
                            pay_d.valid       = word[V_IDX];
                            pay_d.user        = word[U_IDX];
                            pay_d.cstat       = word[C_IDX];
                            pay_d.parity_err  = ^word;
                            pay_d.channel     = (code_q == PRE_W);
                            pay_d.block_start = (code_q == PRE_B);
                            stb_d             = 1'b1;

                            // A bad subframe still strobes but drops lock and history
                            if (pay_d.parity_err || seq_err) begin
                                lock_cnt_d = LOCK_CNT_W'(0);
                                seq_d      = PRE_NONE;
                            end else begin
                                if (lock_cnt_q != LOCK_CNT_W'(LOCK_FRAMES)) begin
                                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                                end
                                seq_d = code_q;
                            end

                            state_d   = PRE;
                            pre_cnt_d = PRE_CNT_W'(0);
                            bit_cnt_d = BIT_CNT_W'(0);
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        // Errors drop lock and sequence history; an L inside DATA is reused
        // as the first interval of the next preamble
        if (err) begin
            lock_cnt_d = LOCK_CNT_W'(0);
            seq_d      = PRE_NONE;
            half_d     = 1'b0;
            bit_cnt_d  = BIT_CNT_W'(0);
            if (restart) begin
                state_d   = PRE;
                hist_d[0] = IV_L;
                pre_cnt_d = PRE_CNT_W'(1);
            end else begin
                state_d   = HUNT;
                pre_cnt_d = PRE_CNT_W'(0);
            end
        end

        lock_d = (lock_cnt_d == LOCK_CNT_W'(LOCK_FRAMES));
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= HUNT;
            pre_cnt_q  <= '0;
            hist_q     <= '0;
            code_q     <= PRE_NONE;
            seq_q      <= PRE_NONE;
            bit_cnt_q  <= '0;
            half_q     <= 1'b0;
            sh_q       <= '0;
            lock_cnt_q <= '0;
            pay_q      <= '0;
            stb_q      <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            hist_q     <= hist_d;
            code_q     <= code_d;
            seq_q      <= seq_d;
            bit_cnt_q  <= bit_cnt_d;
            half_q     <= half_d;
            sh_q       <= sh_d;
            lock_cnt_q <= lock_cnt_d;
            pay_q      <= pay_d;
            stb_q      <= stb_d;
            lock_q     <= lock_d;
        end
    end

    assign o_sample      = pay_q.sample[AUDIO_BITS-1 -: OUT_W];
    assign o_valid       = pay_q.valid;
    assign o_user        = pay_q.user;
    assign o_cstat       = pay_q.cstat;
    assign o_parity_err  = pay_q.parity_err;
    assign o_channel     = pay_q.channel;
    assign o_block_start = pay_q.block_start;
    assign o_stb         = stb_q;
    assign o_lock        = lock_q;

endmodule
